userio_spi_slave: RTL and testbench
===================================

USERIO_SPI_SLAVE -- requirements
Module: userio_spi_slave

Interface
REQ-001 SHALL provide parameter DW, 8, word width in bits (legal 8..32).
REQ-002 SHALL provide parameter CPOL, 1, sck idle level.
REQ-003 SHALL provide parameter CPHA, 1, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL provide parameter SYNC, 2, synchroniser depth for _scs/sck/sdi (legal 2..3).
REQ-005 clk  in  1  system clock; sole clock, all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 _scs  in  1  SPI chip select, active low, asynchronous.
REQ-008 sck  in  1  SPI clock, treated as asynchronous data.
REQ-009 sdi  in  1  SPI serial data in, MSB first.
REQ-010 sdo  out  1  SPI serial data out, MSB first.
REQ-011 tx_data  in  DW  next word to transmit.
REQ-012 tx_load  in  1  write tx_data into TX buffer.
REQ-013 tx_ready  out  1  TX buffer empty.
REQ-014 rx_data  out  DW  last received word.
REQ-015 rx_valid  out  1  rx_data unread; held until rx_ack.
REQ-016 rx_ack  in  1  consumer has read rx_data.
REQ-017 rx_cmd  out  1  rx_data is first word of current frame.
REQ-018 vld  out  1  synchronised chip-select active.
REQ-019 overrun  out  1  sticky: word received while rx_valid=1.
REQ-020 underrun  out  1  sticky: TX load needed while buffer empty.

Function
REQ-021 _scs, sck and sdi SHALL pass through SYNC flip-flops; edges are detected on synchronised sck; clk SHALL be >= 4x sck.
REQ-022 Sample edge SHALL be rising sck when CPOL==CPHA, else falling; shift edge is the opposite edge.
REQ-023 Frame start = synchronised _scs falling; frame end = synchronised _scs rising; vld = synchronised ~_scs.
REQ-024 While deselected, bit counter (0..DW-1) and shift registers SHALL hold 0 and the first-word flag SHALL be 1.
REQ-025 Each sample edge while selected SHALL shift sdi into the RX shift register and increment the bit counter, wrapping DW-1 -> 0.
REQ-026 On the sample edge completing bit DW-1, one clk later rx_data SHALL take the full word, rx_valid=1, rx_cmd=first-word flag, first-word flag cleared.
REQ-027 If rx_valid=1 without rx_ack in the completion cycle, rx_data SHALL still be overwritten and overrun set; rx_ack in the same cycle leaves rx_valid=1 with no overrun.
REQ-028 rx_ack with no completion SHALL clear rx_valid next clk.
REQ-029 Frame end mid-word SHALL discard the partial word with no rx_valid.
REQ-030 TX buffer: tx_load with tx_ready=1 stores tx_data and clears tx_ready next clk; tx_load with tx_ready=0 SHALL be ignored.
REQ-031 TX shift register SHALL load from the buffer on a shift edge with bit counter 0, and additionally at frame start when CPHA=0; other shift edges shift left one, zero-filling.
REQ-032 Load with buffer empty SHALL load all-zero and set underrun; load with buffer full sets tx_ready=1; tx_load in the same cycle as an empty-buffer load fills the buffer for the next word.
REQ-033 sdo SHALL equal TX shift register MSB when synchronised _scs is low, else 0.
REQ-034 overrun and underrun SHALL clear at frame start only.

Reset
REQ-035 reset_n low SHALL asynchronously force: sdo=0, tx_ready=1, rx_data=0, rx_valid=0, rx_cmd=0, vld=0, overrun=0, underrun=0, counters/shift registers 0, synchronisers to deselected/idle (_scs=1, sck=CPOL).
REQ-036 Reset mid-frame SHALL abandon the frame; after release, the block waits for the next frame start.

Verification
REQ-037 DW=8, mode 3: preload 0xA5, frame sends 0x3C -> sdo bits 1010_0101, rx_data=0x3C, rx_valid=1, rx_cmd=1.
REQ-038 DW=16, mode 0: 3-word frame 0x1234,0x5678,0x9ABC with ack after each -> rx_cmd 1,0,0; no overrun; tx words echoed in order.
REQ-039 No rx_ack, two words 0x11,0x22 -> rx_data=0x22, overrun=1; next frame start clears overrun.
REQ-040 Buffer empty at second word -> second word on sdo 0x00, underrun=1; tx_load while tx_ready=0 -> ignored.
REQ-041 _scs deasserted after 5 bits -> no rx_valid; next frame bit counter restarts at 0, rx_cmd=1.
REQ-042 reset_n pulsed mid-word -> all outputs at REQ-035 values; following full frame received correctly.

Source files
------------

// File: rtl/userio_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : userio_spi_slave_if
// Description : User-side word interface of the SPI slave (TX buffer, RX
//               handshake and status flags).
// Revision    : 1.0
// ============================================================================
interface userio_spi_slave_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tx_data;
    logic          tx_load;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ack;
    logic          rx_cmd;
    logic          vld;
    logic          overrun;
    logic          underrun;

    modport slave (
        input  tx_data, tx_load, rx_ack,
        output tx_ready, rx_data, rx_valid, rx_cmd, vld, overrun, underrun
    );

    modport master (
        output tx_data, tx_load, rx_ack,
        input  tx_ready, rx_data, rx_valid, rx_cmd, vld, overrun, underrun
    );
endinterface
`default_nettype wire

// File: rtl/userio_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : userio_spi_slave
// Description : Oversampled SPI slave, all pins synchronised into clk, with a
//               one-word TX buffer and a held RX word with ack handshake.
// Revision    : 1.0
// ============================================================================
module userio_spi_slave #(
    parameter int DW   = 8,
    parameter bit CPOL = 1'b1,
    parameter bit CPHA = 1'b1,
    parameter int SYNC = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              _scs,
    input  logic              sck,
    input  logic              sdi,
    output logic              sdo,
    userio_spi_slave_if.slave bus
);

    localparam int              c_CW          = $clog2(DW);
    localparam logic [c_CW-1:0] c_LAST_BIT    = c_CW'(DW - 1);
    localparam bit              c_SAMPLE_RISE = (CPOL == CPHA);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [SYNC-1:0] r_scs_sync;
    logic [SYNC-1:0] r_sck_sync;
    logic [SYNC-1:0] r_sdi_sync;
    logic            r_sck_prev;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            w_frame_start;

    logic [c_CW-1:0] r_bit_cnt;
    logic [DW-1:0]   r_rx_shift;
    logic            r_first;
    logic [DW-1:0]   r_rx_data;
    logic            r_rx_valid;
    logic            r_rx_cmd;
    logic            r_overrun;

    logic [DW-1:0]   r_tx_buf;
    logic            r_tx_ready;
    logic [DW-1:0]   r_tx_shift;
    logic            r_underrun;

    logic            w_scs_s;
    logic            w_sck_s;
    logic            w_sdi_s;
    logic            w_rise;
    logic            w_fall;
    logic            w_sample;
    logic            w_shift;
    logic            w_bit_last;
    logic            w_word_done;
    logic [DW-1:0]   w_rx_word;
    logic            w_tx_load_evt;

    // ------------------------------------------------------------------
    // Input synchronisers and sck edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scs_sync <= '1;
            r_sck_sync <= {SYNC{CPOL}};
            r_sdi_sync <= '0;
            r_sck_prev <= CPOL;
        end else begin
            r_scs_sync <= {r_scs_sync[SYNC-2:0], _scs};
            r_sck_sync <= {r_sck_sync[SYNC-2:0], sck};
            r_sdi_sync <= {r_sdi_sync[SYNC-2:0], sdi};
            r_sck_prev <= w_sck_s;
        end
    end

    assign w_scs_s  = r_scs_sync[SYNC-1];
    assign w_sck_s  = r_sck_sync[SYNC-1];
    assign w_sdi_s  = r_sdi_sync[SYNC-1];
    assign w_rise   = ~r_sck_prev &  w_sck_s;
    assign w_fall   =  r_sck_prev & ~w_sck_s;
    assign w_sample = ~w_scs_s & (c_SAMPLE_RISE ? w_rise : w_fall);
    assign w_shift  = ~w_scs_s & (c_SAMPLE_RISE ? w_fall : w_rise);

    // ------------------------------------------------------------------
    // Frame tracking FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!w_scs_s) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_scs_s)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_frame_start = 1'b0;
        case (r_state)
            S_IDLE:  w_frame_start = ~w_scs_s;
            default: w_frame_start = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    assign w_bit_last  = (r_bit_cnt == c_LAST_BIT);
    assign w_word_done = w_sample & w_bit_last;
    assign w_rx_word   = {r_rx_shift[DW-2:0], w_sdi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_first    <= 1'b1;
        end else if (w_scs_s) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_first    <= 1'b1;
        end else if (w_sample) begin
            r_rx_shift <= w_rx_word;
            r_bit_cnt  <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
            if (w_bit_last) begin
                r_first <= 1'b0;
            end
        end
    end

    // A word completing on top of an unacknowledged one still replaces it;
    // an ack landing in the completion cycle counts as consuming the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_cmd   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_overrun <= 1'b0;
            end
            if (w_word_done) begin
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
                r_rx_cmd   <= r_first;
                if (r_rx_valid && !bus.rx_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (bus.rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    assign w_tx_load_evt = (w_shift && (r_bit_cnt == '0)) || (!CPHA && w_frame_start);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_buf   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_shift <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_underrun <= 1'b0;
            end

            if (w_scs_s) begin
                r_tx_shift <= '0;
            end else if (w_tx_load_evt) begin
                if (r_tx_ready) begin
                    r_tx_shift <= '0;
                    r_underrun <= 1'b1;
                end else begin
                    r_tx_shift <= r_tx_buf;
                end
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DW-2:0], 1'b0};
            end

            // Empty-buffer load leaves this cycle free for a tx_load to refill.
            if (w_tx_load_evt && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end else if (bus.tx_load && r_tx_ready) begin
                r_tx_buf   <= bus.tx_data;
                r_tx_ready <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sdo          = w_scs_s ? 1'b0 : r_tx_shift[DW-1];
    assign bus.vld      = ~w_scs_s;
    assign bus.tx_ready = r_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_cmd   = r_rx_cmd;
    assign bus.overrun  = r_overrun;
    assign bus.underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_userio_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_userio_spi_slave
// Description : Bench for two SPI slave instances (DW=8 mode 3, DW=16 mode 0)
//               driven as SPI master against a word-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_userio_spi_slave;

    localparam int HALF = 6;

    typedef struct {
        logic [31:0] data;
        logic        cmd;
    } rx_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] scs;
    logic [1:0] sck;
    logic [1:0] sdi;
    logic [1:0] sdo;

    int checks = 0;
    int errors = 0;

    bit          m_full  [2];
    logic [31:0] m_val   [2];
    bit          m_under [2];
    bit          ack_en  [2];
    rx_t         q0 [$];
    rx_t         q1 [$];
    rx_t         e0, e1;
    logic [31:0] rxw [4];
    logic [31:0] txw [4];

    always #5 clk = ~clk;

    userio_spi_slave_if #(.DW(8))  ifa ();
    userio_spi_slave_if #(.DW(16)) ifb ();

    userio_spi_slave #(.DW(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC(2)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        ._scs    (scs[0]),
        .sck     (sck[0]),
        .sdi     (sdi[0]),
        .sdo     (sdo[0]),
        .bus     (ifa.slave)
    );

    userio_spi_slave #(.DW(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC(3)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        ._scs    (scs[1]),
        .sck     (sck[1]),
        .sdi     (sdi[1]),
        .sdo     (sdo[1]),
        .bus     (ifb.slave)
    );

    function automatic int dwid(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic bit cpol(input int i);
        return (i == 0);
    endfunction

    function automatic bit cpha(input int i);
        return (i == 0);
    endfunction

    function automatic logic [31:0] wmask(input int i);
        return (i == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // The buffer hands over its word if one is pending, otherwise zeros + underrun.
    task automatic model_load(input int i, output logic [31:0] v);
        if (m_full[i]) begin
            v         = m_val[i];
            m_full[i] = 1'b0;
        end else begin
            v          = 32'd0;
            m_under[i] = 1'b1;
        end
    endtask

    task automatic try_load(input int i, input logic [31:0] v);
        @(negedge clk);
        check($sformatf("tx_ready%0d", i), 32'(i == 0 ? ifa.tx_ready : ifb.tx_ready), 32'(!m_full[i]));
        if (i == 0) begin
            ifa.tx_data = v[7:0];
            ifa.tx_load = 1'b1;
        end else begin
            ifb.tx_data = v[15:0];
            ifb.tx_load = 1'b1;
        end
        @(negedge clk);
        ifa.tx_load = 1'b0;
        ifb.tx_load = 1'b0;
        if (!m_full[i]) begin
            m_full[i] = 1'b1;
            m_val[i]  = v & wmask(i);
        end
    endtask

    // One frame of nw words from rxw[]; the last word carries last_bits bits.
    // Bit w of ldmask loads txw[w] into the TX buffer just before word w.
    task automatic frame(input int i, input int nw, input int last_bits, input int ldmask);
        int          n;
        int          nb;
        bit          first;
        logic [31:0] cur;
        logic [31:0] got;
        n     = dwid(i);
        first = 1'b1;
        cur   = 32'd0;
        @(negedge clk);
        scs[i]     = 1'b0;
        m_under[i] = 1'b0;
        if (!cpha(i)) model_load(i, cur);
        repeat (HALF) @(negedge clk);
        check($sformatf("vld_on%0d", i), 32'(i == 0 ? ifa.vld : ifb.vld), 32'd1);
        for (int w = 0; w < nw; w++) begin
            repeat (HALF) @(negedge clk);
            if (ldmask[w]) try_load(i, txw[w]);
            nb = (w == nw - 1) ? last_bits : n;
            if (nb == n && ack_en[i]) begin
                if (i == 0) q0.push_back('{rxw[w] & wmask(i), first});
                else        q1.push_back('{rxw[w] & wmask(i), first});
            end
            if (cpha(i)) model_load(i, cur);
            got = 32'd0;
            for (int b = 0; b < nb; b++) begin
                if (!cpha(i)) begin
                    sdi[i] = rxw[w][n-1-b];
                    repeat (HALF) @(negedge clk);
                    got    = {got[30:0], sdo[i]};
                    sck[i] = !cpol(i);
                    repeat (HALF) @(negedge clk);
                    sck[i] = cpol(i);
                end else begin
                    sck[i] = !cpol(i);
                    sdi[i] = rxw[w][n-1-b];
                    repeat (HALF) @(negedge clk);
                    got    = {got[30:0], sdo[i]};
                    sck[i] = cpol(i);
                    repeat (HALF) @(negedge clk);
                end
            end
            check($sformatf("sdo_word%0d_w%0d", i, w), got, cur >> (n - nb));
            if (nb == n) begin
                first = 1'b0;
                if (!cpha(i)) model_load(i, cur);
            end
        end
        repeat (HALF) @(negedge clk);
        scs[i] = 1'b1;
        sdi[i] = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        check($sformatf("vld_off%0d", i), 32'(i == 0 ? ifa.vld : ifb.vld), 32'd0);
        check($sformatf("underrun%0d", i), 32'(i == 0 ? ifa.underrun : ifb.underrun), 32'(m_under[i]));
        if (ack_en[i]) begin
            check($sformatf("overrun%0d", i), 32'(i == 0 ? ifa.overrun : ifb.overrun), 32'd0);
        end
    endtask

    task automatic check_reset(input int i);
        if (i == 0) begin
            check("rst_sdo0",      32'(sdo[0]),       32'd0);
            check("rst_tx_ready0", 32'(ifa.tx_ready), 32'd1);
            check("rst_rx_data0",  32'(ifa.rx_data),  32'd0);
            check("rst_rx_valid0", 32'(ifa.rx_valid), 32'd0);
            check("rst_rx_cmd0",   32'(ifa.rx_cmd),   32'd0);
            check("rst_vld0",      32'(ifa.vld),      32'd0);
            check("rst_overrun0",  32'(ifa.overrun),  32'd0);
            check("rst_underrun0", 32'(ifa.underrun), 32'd0);
        end else begin
            check("rst_sdo1",      32'(sdo[1]),       32'd0);
            check("rst_tx_ready1", 32'(ifb.tx_ready), 32'd1);
            check("rst_rx_data1",  32'(ifb.rx_data),  32'd0);
            check("rst_rx_valid1", 32'(ifb.rx_valid), 32'd0);
            check("rst_rx_cmd1",   32'(ifb.rx_cmd),   32'd0);
            check("rst_vld1",      32'(ifb.vld),      32'd0);
            check("rst_overrun1",  32'(ifb.overrun),  32'd0);
            check("rst_underrun1", 32'(ifb.underrun), 32'd0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i]  = 1'b0;
            m_val[i]   = 32'd0;
            m_under[i] = 1'b0;
        end
    endtask

    // Receive monitors: compare each presented word, then pulse rx_ack.
    always @(negedge clk) begin
        if (!reset_n || ifa.rx_ack === 1'b1) begin
            ifa.rx_ack = 1'b0;
        end else if (ack_en[0] && ifa.rx_valid === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected0 actual=%h required=none", ifa.rx_data);
            end else begin
                e0 = q0.pop_front();
                check("rx_data0", 32'(ifa.rx_data), e0.data);
                check("rx_cmd0",  32'(ifa.rx_cmd),  32'(e0.cmd));
            end
            ifa.rx_ack = 1'b1;
        end else begin
            ifa.rx_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset_n || ifb.rx_ack === 1'b1) begin
            ifb.rx_ack = 1'b0;
        end else if (ack_en[1] && ifb.rx_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected1 actual=%h required=none", ifb.rx_data);
            end else begin
                e1 = q1.pop_front();
                check("rx_data1", 32'(ifb.rx_data), e1.data);
                check("rx_cmd1",  32'(ifb.rx_cmd),  32'(e1.cmd));
            end
            ifb.rx_ack = 1'b1;
        end else begin
            ifb.rx_ack = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int nw;
        int lb;
        reset_n     = 1'b0;
        scs         = 2'b11;
        sck         = 2'b01;
        sdi         = 2'b00;
        ifa.tx_load = 1'b0;
        ifa.tx_data = '0;
        ifb.tx_load = 1'b0;
        ifb.tx_data = '0;
        ack_en[0]   = 1'b1;
        ack_en[1]   = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // DW=8 mode 3: preload 0xA5, receive 0x3C as command word
        try_load(0, 32'hA5);
        rxw[0] = 32'h3C;
        frame(0, 1, 8, 0);

        // DW=16 mode 0: three words, TX words echoed one load ahead
        try_load(1, 32'hA1B2);
        rxw[0] = 32'h1234; rxw[1] = 32'h5678; rxw[2] = 32'h9ABC;
        txw[0] = 32'hC3D4; txw[1] = 32'hE5F6; txw[2] = 32'h0F1E;
        frame(1, 3, 16, 7);

        // No ack across two words: overrun, latest word kept
        ack_en[0] = 1'b0;
        rxw[0] = 32'h11; rxw[1] = 32'h22;
        frame(0, 2, 8, 0);
        check("ovr_rx_data",  32'(ifa.rx_data),  32'h22);
        check("ovr_rx_valid", 32'(ifa.rx_valid), 32'd1);
        check("ovr_rx_cmd",   32'(ifa.rx_cmd),   32'd0);
        check("ovr_flag",     32'(ifa.overrun),  32'd1);
        q0.push_back('{32'h22, 1'b0});
        ack_en[0] = 1'b1;
        repeat (4) @(negedge clk);
        try_load(0, 32'h77);
        rxw[0] = 32'h5A;
        frame(0, 1, 8, 0);

        // Buffer empty for second word; a second load while full is dropped
        try_load(0, 32'h96);
        try_load(0, 32'h69);
        rxw[0] = 32'h01; rxw[1] = 32'h02;
        frame(0, 2, 8, 0);

        // Frame aborted after 5 bits, then a full frame restarts cleanly
        for (int k = 0; k < 2; k++) begin
            rxw[0] = 32'hF0F0;
            frame(k, 1, 5, 0);
            rxw[0] = 32'h0F0F;
            frame(k, 1, dwid(k), 0);
        end

        // Reset pulsed in the middle of a mode-0 word
        @(negedge clk);
        scs[1] = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            sdi[1] = b[0];
            repeat (HALF) @(negedge clk);
            sck[1] = 1'b1;
            repeat (HALF) @(negedge clk);
            sck[1] = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        scs[1]  = 1'b1;
        sdi[1]  = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        try_load(1, 32'hBEEF);
        rxw[0] = 32'hCAFE;
        frame(1, 1, 16, 0);
        rxw[0] = 32'h81;
        frame(0, 1, 8, 0);

        // Randomised frames on both instances
        for (int k = 0; k < 24; k++) begin
            i  = k % 2;
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) begin
                rxw[w] = $urandom;
                txw[w] = $urandom;
            end
            if ($urandom_range(0, 1) == 0) try_load(i, $urandom);
            lb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, dwid(i) - 1) : dwid(i);
            frame(i, nw, lb, $urandom_range(0, 7));
        end

        repeat (10) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
